// File: rtl/kws_pkg.sv
// Shared types and constants for the KWS Wishbone classic burst initiator.
package kws_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_ADR_W-1:0] ADR_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/kws_timeout_cnt.sv
// Counts cycles spent waiting on the bus and flags when the wait limit is reached.
module kws_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // expired fires during the TIMEOUT_CYCLES-th enabled cycle, so the abort lands on its closing edge
    assign expired = enable && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kws_wb_master.sv
// Command-to-Wishbone classic burst initiator with per-beat responses, timeout and error abort.
module kws_wb_master
    import kws_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_LEN_W      = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [WB_SEL_W-1:0]  cmd_sel_i,
    input  logic [WB_ADR_W-1:0]  cmd_adr_i,
    input  logic [WB_DAT_W-1:0]  cmd_dat_i,
    input  logic [MAX_LEN_W-1:0] cmd_len_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WB_DAT_W-1:0]  rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 rsp_last_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    output logic [WB_ADR_W-1:0]  wbm_adr_o,
    output logic [WB_DAT_W-1:0]  wbm_dat_o,
    input  logic [WB_DAT_W-1:0]  wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic                 busy_o
);

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [WB_SEL_W-1:0]  sel_q, sel_d;
    logic [WB_ADR_W-1:0]  adr_q, adr_d;
    logic [WB_DAT_W-1:0]  dat_q, dat_d;
    logic [MAX_LEN_W-1:0] left_q, left_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WB_DAT_W-1:0]  rsp_dat_q, rsp_dat_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_last_q, rsp_last_d;
    logic                 tmo_clear;
    logic                 tmo_expired;

    kws_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clear  (tmo_clear),
        .enable (state_q == ST_BUS),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        left_d      = left_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        tmo_clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d      = cmd_we_i;
                    sel_d     = cmd_sel_i;
                    adr_d     = cmd_adr_i;
                    dat_d     = cmd_dat_i;
                    left_d    = cmd_len_i;
                    cyc_d     = 1'b1;
                    tmo_clear = 1'b1;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                // err and timeout both abort the burst; err wins over a simultaneous ack
                if (wbm_err_i || tmo_expired) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = ST_RESP;
                end else if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_last_d  = (left_q == '0);
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (!rsp_err_q && (left_q != '0)) begin
                        adr_d     = adr_q + ADR_INC;
                        left_d    = left_q - 1'b1;
                        cyc_d     = 1'b1;
                        tmo_clear = 1'b1;
                        state_d   = ST_BUS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            left_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            left_q      <= left_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_last_o  = rsp_last_q;

endmodule
